mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported backing memory between the instruction-fetch port and the data-access port of the five-stage pipeline. It serialises requests through a fixed-latency access sequencer, returns read data to the granted requester, and provides stall indications that the pipeline uses to gate its PC and pipeline-register write enables. It replaces the two independent memory instances with one arbitrated port.

## Interface
- LATENCY, 4, backing-memory cycles per access; legal range 1..15
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch read data; valid while if_ready, held until the next fetch completes
- if_ready  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_ready (combinational)
- d_req  in  1  data request, held until d_ready
- d_write  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; valid while d_ready, held until the next load completes
- d_ready  out  1  one-cycle data completion pulse
- d_stall  out  1  d_req & ~d_ready (combinational)
- mem_addr  out  32  backing-memory address
- mem_wdata  out  32  backing-memory write data
- mem_read  out  1  backing-memory read strobe
- mem_write  out  1  backing-memory write strobe
- mem_rdata  in  32  backing-memory read data, valid in the last BUSY cycle

## Operation
- States: IDLE, BUSY_I, BUSY_D. Registers: grant address, write data, write flag, down-counter (4 bits), last_grant, if_ready, d_ready, if_rdata, d_rdata.
- IDLE: the block samples requests at the clock edge. A port whose ready output is high in this cycle has its req ignored, because that req belongs to the transfer just completed.
- Eligible d_req only: go to BUSY_D. Eligible if_req only: go to BUSY_I. Both eligible: go to BUSY_D (see Configuration). Entering BUSY latches addr, wdata, and write flag, loads counter = LATENCY-1, and sets last_grant.
- BUSY_x: mem_addr and mem_wdata come from the latched registers and are stable for the whole access. mem_read = ~write, mem_write = write. The counter decrements every cycle.
- BUSY_x with counter == 0: at the edge, return to IDLE, pulse x_ready for the following cycle, and load x_rdata from mem_rdata for reads. Stores leave d_rdata unchanged.
- In IDLE, mem_read = mem_write = 0. mem_addr and mem_wdata hold their last values.
- Addresses pass through unmodified. No alignment check.
- Reset (asynchronous, any state): go to IDLE. The counter, last_grant (= data), ready outputs, rdata registers, mem_read, mem_write, mem_addr, and mem_wdata all clear to 0. An in-flight access is abandoned and no ready pulse is issued.

## Timing
- Request sampled at the end of cycle T. BUSY occupies cycles T+1..T+LATENCY. x_ready is high in cycle T+LATENCY+1.
- Throughput: at most one access per LATENCY+1 cycles. The ready cycle is always an IDLE cycle.
- A back-to-back request on the other port, pending during the ready cycle, is granted at the end of the ready cycle.
- if_stall and d_stall are combinational from the req inputs and the registered ready outputs. There is no path from the mem_* inputs to any output.

## Configuration
- ARB_FAIR_EN defined: on a tie in IDLE, grant the port opposite to last_grant. last_grant resets to data, so the first tie after reset grants fetch.
- ARB_FAIR_EN undefined: on a tie, data always wins. last_grant is still maintained but unused.

## Test plan
- LATENCY=4, if_req with if_addr=0x10 sampled at cycle 0, mem_rdata=0xDEADBEEF -> mem_read=1 and mem_addr=0x10 in cycles 1-4; if_ready=1 and if_rdata=0xDEADBEEF in cycle 5 only; if_stall=1 in cycles 0-4.
- Store with d_addr=0x100, d_wdata=0x1234, and d_rdata previously 0xAAAA -> mem_write=1 with those values for 4 cycles; mem_read=0; d_ready pulse; d_rdata stays 0xAAAA.
- Tie without ARB_FAIR_EN: if_req and d_req both sampled at cycle 0, both held -> d_ready in cycle 5, fetch granted at the end of cycle 5, if_ready in cycle 10.
- Tie with ARB_FAIR_EN straight after reset -> fetch served first (if_ready in cycle 5). The next tie after a fetch grant goes to data.
- Held request across the ready cycle: d_req stays high in the d_ready cycle with no if_req -> no regrant that cycle; d_req is granted at the next edge; d_ready arrives LATENCY+1 cycles later.
- reset asserted in the 2nd BUSY_I cycle -> mem_read drops immediately with no if_ready pulse. After reset release with if_req still high, the fetch is regranted and completes LATENCY+1 cycles after the first sampling edge.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of the fetch port, data port and backing-memory
// port that mem_arbiter connects together.
//
// Signals:
//   if_req/if_addr        fetch request and byte address (pipeline -> arbiter)
//   if_rdata/if_ready     fetch read data and one-cycle completion pulse
//   if_stall              fetch stall (if_req & ~if_ready)
//   d_req/d_write/d_addr/d_wdata  data request, store flag, address, store data
//   d_rdata/d_ready       load data and one-cycle completion pulse
//   d_stall               data stall (d_req & ~d_ready)
//   mem_addr/mem_wdata/mem_read/mem_write  backing-memory command
//   mem_rdata             backing-memory read data
//
// Modports:
//   slave  -- the arbiter's view
//   master -- the environment's view (pipeline plus memory model)
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output if_req, if_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-ported backing memory between the
// instruction-fetch port and the data-access port. Each access occupies the
// memory for LATENCY cycles; the requester gets a one-cycle ready pulse in
// the following (idle) cycle, together with the read data.
//
// Parameters:
//   LATENCY  backing-memory cycles per access, 1..15
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; abandons any in-flight access
//   bus    mem_arbiter_if.slave (fetch port, data port, memory port)
//
// Build option:
//   ARB_FAIR_EN  when defined, a simultaneous fetch/data request is granted to
//                the port opposite to the previous grant; otherwise data wins.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic        last_grant;   // 1 = fetch, 0 = data
  logic        write_flag;
  logic        if_ready;
  logic        d_ready;
  logic [31:0] if_rdata;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;

  logic        if_elig;
  logic        d_elig;
  logic        tie_data;
  logic        grant_i;
  logic        grant_d;
  logic        done;

  // A port whose ready is high is finishing the transfer that req belongs to.
  assign if_elig = bus.if_req & ~if_ready;
  assign d_elig  = bus.d_req & ~d_ready;
  assign done    = (state != IDLE) && (count == 4'd0);

`ifdef ARB_FAIR_EN
  // Alternate on ties: the port that was not granted last time wins.
  assign tie_data = last_grant;
`else
  // Data always wins a tie; last_grant is tracked but has no say here.
  assign tie_data = 1'b1 | last_grant;
`endif

  // Next-state and grant decision.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_elig && if_elig) begin
          grant_d = tie_data;
          grant_i = ~tie_data;
        end else if (d_elig) begin
          grant_d = 1'b1;
        end else if (if_elig) begin
          grant_i = 1'b1;
        end else begin
          grant_d = 1'b0;
        end
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_i) begin
          state_next = BUSY_I;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (count == 4'd0) begin
          state_next = IDLE;
        end else begin
          state_next = state;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Access latching, latency counter, ready pulses and returned data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= 4'd0;
      last_grant <= 1'b0;
      write_flag <= 1'b0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= 32'd0;
      d_rdata    <= 32'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (grant_d) begin
        mem_addr   <= bus.d_addr;
        mem_wdata  <= bus.d_wdata;
        write_flag <= bus.d_write;
        mem_read   <= ~bus.d_write;
        mem_write  <= bus.d_write;
        count      <= CNT_LOAD;
        last_grant <= 1'b0;
      end else if (grant_i) begin
        // Fetches never write, so the store data register is left alone.
        mem_addr   <= bus.if_addr;
        write_flag <= 1'b0;
        mem_read   <= 1'b1;
        mem_write  <= 1'b0;
        count      <= CNT_LOAD;
        last_grant <= 1'b1;
      end else if (done) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (state == BUSY_I) begin
          if_ready <= 1'b1;
          if_rdata <= bus.mem_rdata;
        end else begin
          d_ready <= 1'b1;
          if (!write_flag) begin
            d_rdata <= bus.mem_rdata;
          end
        end
      end else if (state != IDLE) begin
        count <= count - 4'd1;
      end
    end
  end

  assign bus.if_ready  = if_ready;
  assign bus.d_ready   = d_ready;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_rdata   = d_rdata;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.if_stall  = bus.if_req & ~if_ready;
  assign bus.d_stall   = bus.d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with LATENCY = 4.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_arbiter_if bus ();

  mem_arbiter #(.LATENCY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Fetch-only access, entered in cycle 0 (request sampled at its end).
  task automatic single_fetch(input logic [31:0] addr, input logic [31:0] rd);
    bus.if_req    = 1'b1;
    bus.if_addr   = addr;
    bus.mem_rdata = rd;
    #1;
    chk("f_stall_c0", {31'd0, bus.if_stall}, 32'd1);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("f_mem_read", {31'd0, bus.mem_read}, 32'd1);
      chk("f_mem_write", {31'd0, bus.mem_write}, 32'd0);
      chk("f_mem_addr", bus.mem_addr, addr);
      chk("f_ready_busy", {31'd0, bus.if_ready}, 32'd0);
      chk("f_stall_busy", {31'd0, bus.if_stall}, 32'd1);
    end
    step();
    chk("f_ready", {31'd0, bus.if_ready}, 32'd1);
    chk("f_rdata", bus.if_rdata, rd);
    chk("f_stall_rdy", {31'd0, bus.if_stall}, 32'd0);
    chk("f_mem_read_rdy", {31'd0, bus.mem_read}, 32'd0);
    bus.if_req    = 1'b0;
    bus.mem_rdata = 32'h5A5A_5A5A;
    step();
    chk("f_ready_drop", {31'd0, bus.if_ready}, 32'd0);
    chk("f_rdata_hold", bus.if_rdata, rd);
    chk("f_idle_read", {31'd0, bus.mem_read}, 32'd0);
  endtask

  // Simultaneous fetch and data load, both held until served.
  task automatic tie(input logic data_first);
    logic [31:0] a_first;
    logic [31:0] a_second;
    a_first  = data_first ? 32'h0000_0300 : 32'h0000_0040;
    a_second = data_first ? 32'h0000_0040 : 32'h0000_0300;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0040;
    bus.d_req     = 1'b1;
    bus.d_write   = 1'b0;
    bus.d_addr    = 32'h0000_0300;
    bus.mem_rdata = 32'h0BAD_F00D;
    step();
    chk("tie_first_addr", bus.mem_addr, a_first);
    chk("tie_first_read", {31'd0, bus.mem_read}, 32'd1);
    for (int c = 2; c <= 5; c++) step();
    chk("tie_if_ready_c5", {31'd0, bus.if_ready}, {31'd0, ~data_first});
    chk("tie_d_ready_c5", {31'd0, bus.d_ready}, {31'd0, data_first});
    chk("tie_if_stall_c5", {31'd0, bus.if_stall}, {31'd0, data_first});
    if (data_first) bus.d_req = 1'b0;
    else bus.if_req = 1'b0;
    bus.mem_rdata = 32'h600D_CAFE;
    step();
    chk("tie_second_addr", bus.mem_addr, a_second);
    chk("tie_second_read", {31'd0, bus.mem_read}, 32'd1);
    for (int c = 7; c <= 10; c++) step();
    chk("tie_if_ready_c10", {31'd0, bus.if_ready}, {31'd0, data_first});
    chk("tie_d_ready_c10", {31'd0, bus.d_ready}, {31'd0, ~data_first});
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    step();
  endtask

  initial begin
    logic fair_first_data;
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.d_req     = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_addr    = 32'd0;
    bus.d_wdata   = 32'd0;
    bus.mem_rdata = 32'd0;
    step();
    step();
    chk("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;
    step();

    // Basic fetch.
    single_fetch(32'h0000_0010, 32'hDEAD_BEEF);

    // Load with d_req held through the ready cycle (a second load follows).
    bus.d_req     = 1'b1;
    bus.d_write   = 1'b0;
    bus.d_addr    = 32'h0000_0200;
    bus.mem_rdata = 32'h0000_1111;
    for (int c = 1; c <= 5; c++) step();
    chk("ld1_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("ld1_rdata", bus.d_rdata, 32'h0000_1111);
    chk("ld1_stall", {31'd0, bus.d_stall}, 32'd0);
    bus.d_addr    = 32'h0000_0204;
    bus.mem_rdata = 32'h0000_AAAA;
    step();
    chk("hold_no_regrant", {31'd0, bus.mem_read}, 32'd0);
    chk("hold_ready_drop", {31'd0, bus.d_ready}, 32'd0);
    chk("hold_stall", {31'd0, bus.d_stall}, 32'd1);
    step();
    chk("ld2_mem_addr", bus.mem_addr, 32'h0000_0204);
    chk("ld2_mem_read", {31'd0, bus.mem_read}, 32'd1);
    for (int c = 8; c <= 10; c++) step();
    chk("ld2_not_ready", {31'd0, bus.d_ready}, 32'd0);
    step();
    chk("ld2_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("ld2_rdata", bus.d_rdata, 32'h0000_AAAA);
    bus.d_req = 1'b0;
    step();

    // Store: d_rdata must keep the previous load value.
    bus.d_req     = 1'b1;
    bus.d_write   = 1'b1;
    bus.d_addr    = 32'h0000_0100;
    bus.d_wdata   = 32'h0000_1234;
    bus.mem_rdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("st_mem_write", {31'd0, bus.mem_write}, 32'd1);
      chk("st_mem_read", {31'd0, bus.mem_read}, 32'd0);
      chk("st_mem_addr", bus.mem_addr, 32'h0000_0100);
      chk("st_mem_wdata", bus.mem_wdata, 32'h0000_1234);
    end
    step();
    chk("st_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("st_rdata_kept", bus.d_rdata, 32'h0000_AAAA);
    chk("st_mem_write_off", {31'd0, bus.mem_write}, 32'd0);
    bus.d_req   = 1'b0;
    bus.d_write = 1'b0;
    step();

    // Reset in the second BUSY_I cycle abandons the fetch.
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0080;
    bus.mem_rdata = 32'h1357_9BDF;
    step();
    step();
    chk("rb_mem_read_pre", {31'd0, bus.mem_read}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rb_mem_read_drop", {31'd0, bus.mem_read}, 32'd0);
    chk("rb_mem_addr_clr", bus.mem_addr, 32'd0);
    step();
    chk("rb_no_ready", {31'd0, bus.if_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rb_regrant_read", {31'd0, bus.mem_read}, 32'd1);
    chk("rb_regrant_addr", bus.mem_addr, 32'h0000_0080);
    for (int c = 2; c <= 4; c++) step();
    chk("rb_not_ready_c4", {31'd0, bus.if_ready}, 32'd0);
    step();
    chk("rb_ready_c5", {31'd0, bus.if_ready}, 32'd1);
    chk("rb_rdata", bus.if_rdata, 32'h1357_9BDF);
    bus.if_req = 1'b0;
    step();

    // Ties: first one straight after a fresh reset, second after a fetch grant.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
`ifdef ARB_FAIR_EN
    fair_first_data = 1'b0;
`else
    fair_first_data = 1'b1;
`endif
    tie(fair_first_data);
    single_fetch(32'h0000_0044, 32'h2468_ACE0);
    tie(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
